// File: rtl/mem_responder_pkg.sv
// Shared types, size encodings and the access-fault rule for mem_responder.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // Range check relies on 32-bit wrap so addresses below base also fault.
    function automatic logic access_fault(
        input logic        rd,
        input logic        we,
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] span,
        input logic [1:0]  size
    );
        logic [31:0] off;
        off = addr - base;
        return (size == SZ_ILL)
            || (size == SZ_HALF && addr[0])
            || (size == SZ_WORD && addr[1:0] != 2'b00)
            || (off >= span)
            || (rd && we);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU memory port bundle: request from the initiator, registered response back.
interface mem_responder_if;

    logic        rd;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [31:0] out;
    logic        ready;
    logic        error;

    modport master (output rd, we, addr, data, size, input out, ready, error);
    modport slave  (input rd, we, addr, data, size, output out, ready, error);

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering shared by both directions: write mask/replication and read extraction.
module mem_lane_align
    import mem_responder_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  wmask,
    output logic [31:0] wrep,
    output logic [31:0] rdata
);

    logic [31:0] shifted;

    assign shifted = rword >> {offset, 3'b000};

    always_comb begin
        wmask = 4'b0000;
        wrep  = wdata;
        rdata = 32'h0;
        case (size)
            SZ_BYTE: begin
                wmask = 4'b0001 << offset;
                wrep  = {4{wdata[7:0]}};
                rdata = {24'h0, shifted[7:0]};
            end
            SZ_HALF: begin
                wmask = offset[1] ? 4'b1100 : 4'b0011;
                wrep  = {2{wdata[15:0]}};
                rdata = {16'h0, shifted[15:0]};
            end
            SZ_WORD: begin
                wmask = 4'b1111;
                rdata = shifted;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Word RAM responder with wait states, lane steering and fault flagging.
// Optional MEM_RESPONDER_FAULT_CAPTURE_EN adds sticky fault_addr/fault_valid outputs.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter logic [31:0] BASE        = 32'h0000_0000,
    parameter int          DEPTH       = 4096,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic                clk,
    input  logic                rst,
`ifdef MEM_RESPONDER_FAULT_CAPTURE_EN
    output logic [31:0]         fault_addr,
    output logic                fault_valid,
`endif
    mem_responder_if.slave      bus
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [31:0] SPAN     = 32'(DEPTH * 4);
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rd_q, rd_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, data_q, data_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] out_q, out_d;
    logic        error_q, error_d;

    logic [31:0] mem [DEPTH];

    logic          idle, cur_rd, cur_we, fault, wr_en;
    logic [31:0]   cur_addr, cur_data, wrep, rdata;
    logic [1:0]    cur_size;
    logic [AW-1:0] idx;
    logic [3:0]    wmask;

    // In IDLE the live request is used so a zero-wait access responds next cycle.
    assign idle     = (state_q == IDLE);
    assign cur_rd   = idle ? bus.rd   : rd_q;
    assign cur_we   = idle ? bus.we   : we_q;
    assign cur_addr = idle ? bus.addr : addr_q;
    assign cur_data = idle ? bus.data : data_q;
    assign cur_size = idle ? bus.size : size_q;
    assign idx      = AW'((cur_addr - BASE) >> 2);
    assign fault    = access_fault(cur_rd, cur_we, cur_addr, BASE, SPAN, cur_size);
    assign wr_en    = (state_q == RESP) && we_q && !error_q;

    mem_lane_align u_align (
        .size   (cur_size),
        .offset (cur_addr[1:0]),
        .wdata  (cur_data),
        .rword  (mem[idx]),
        .wmask  (wmask),
        .wrep   (wrep),
        .rdata  (rdata)
    );

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        size_d  = size_q;
        out_d   = out_q;
        error_d = error_q;
        case (state_q)
            IDLE: begin
                if (bus.rd || bus.we) begin
                    rd_d    = bus.rd;
                    we_d    = bus.we;
                    addr_d  = bus.addr;
                    data_d  = bus.data;
                    size_d  = bus.size;
                    cnt_d   = CNT_INIT;
                    state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == RESP) begin
            error_d = fault;
            out_d   = (cur_rd && !cur_we && !fault) ? rdata : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            data_q  <= 32'h0;
            size_q  <= 2'b00;
            out_q   <= 32'h0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            size_q  <= size_d;
            out_q   <= out_d;
            error_q <= error_d;
        end
    end

    assign bus.out   = out_q;
    assign bus.error = error_q;
    assign bus.ready = (state_q == RESP);

`ifdef MEM_RESPONDER_FAULT_CAPTURE_EN
    logic [31:0] fault_addr_q, fault_addr_d;
    logic        fault_valid_q, fault_valid_d;

    // First fault wins; later faults leave the capture untouched until reset.
    always_comb begin
        fault_addr_d  = fault_addr_q;
        fault_valid_d = fault_valid_q;
        if (state_q == RESP && error_q && !fault_valid_q) begin
            fault_addr_d  = addr_q;
            fault_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_addr_q  <= 32'h0;
            fault_valid_q <= 1'b0;
        end else begin
            fault_addr_q  <= fault_addr_d;
            fault_valid_q <= fault_valid_d;
        end
    end

    assign fault_addr  = fault_addr_q;
    assign fault_valid = fault_valid_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: zero-wait and 3-wait responders against a byte-addressed reference memory.
module tb_mem_responder;

    localparam logic [31:0] B0 = 32'h0000_0000;
    localparam logic [31:0] S0 = 32'h0000_4000;
    localparam logic [31:0] B3 = 32'h0000_1000;
    localparam logic [31:0] S3 = 32'h0000_0400;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    mem_responder_if bus0 ();
    mem_responder_if bus3 ();

`ifdef MEM_RESPONDER_FAULT_CAPTURE_EN
    logic [31:0] fa0, fa3;
    logic        fv0, fv3;
`endif

    mem_responder #(.BASE(B0), .DEPTH(4096), .WAIT_CYCLES(0)) u0 (
        .clk         (clk),
        .rst         (rst),
`ifdef MEM_RESPONDER_FAULT_CAPTURE_EN
        .fault_addr  (fa0),
        .fault_valid (fv0),
`endif
        .bus         (bus0)
    );

    mem_responder #(.BASE(B3), .DEPTH(256), .WAIT_CYCLES(3)) u3 (
        .clk         (clk),
        .rst         (rst),
`ifdef MEM_RESPONDER_FAULT_CAPTURE_EN
        .fault_addr  (fa3),
        .fault_valid (fv3),
`endif
        .bus         (bus3)
    );

    // Reference: byte-addressed little-endian memory, keyed by {dut, address}.
    logic [7:0] mm [bit [32:0]];

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic m_fault(input logic r, input logic w, input logic [31:0] a,
                                     input logic [31:0] base, input logic [31:0] span,
                                     input logic [1:0] s);
        int unsigned a_u, b_u, sp_u;
        a_u = a; b_u = base; sp_u = span;
        if (s == 2'b11) return 1'b1;
        if (r && w) return 1'b1;
        if ((a_u % nbytes(s)) != 0) return 1'b1;
        if (a_u < b_u || a_u - b_u >= sp_u) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input int d, input logic [31:0] a, input logic [1:0] s);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < nbytes(s); i++) v = v | (32'(mm[{d[0], a + 32'(i)}]) << (8 * i));
        return v;
    endfunction

    task automatic m_write(input int d, input logic [31:0] a, input logic [31:0] dt, input logic [1:0] s);
        for (int i = 0; i < nbytes(s); i++) mm[{d[0], a + 32'(i)}] = dt[8*i +: 8];
    endtask

    task automatic drive(input int d, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] dt, input logic [1:0] s);
        if (d == 0) begin
            bus0.rd = r; bus0.we = w; bus0.addr = a; bus0.data = dt; bus0.size = s;
        end else begin
            bus3.rd = r; bus3.we = w; bus3.addr = a; bus3.data = dt; bus3.size = s;
        end
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? bus0.ready : bus3.ready;
    endfunction

    // Starts in an IDLE cycle (#1 after an edge), ends in the following IDLE cycle.
    task automatic txn(input int d, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] dt, input logic [1:0] s,
                       output logic [31:0] o, output logic e, output int lat);
        drive(d, r, w, a, dt, s);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!rdy(d) && lat < 40);
        o = (d == 0) ? bus0.out : bus3.out;
        e = (d == 0) ? bus0.error : bus3.error;
        drive(d, 1'b0, 1'b0, a, dt, s);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0);
        drive(3, 0, 0, 0, 0, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus0.out, bus0.ready, bus0.error} !== 34'h0) begin
            errors++; $display("FAIL reset_u0 got out=%h rdy=%b err=%b want 0", bus0.out, bus0.ready, bus0.error);
        end
        checks++;
        if ({bus3.out, bus3.ready, bus3.error} !== 34'h0) begin
            errors++; $display("FAIL reset_u3 got out=%h rdy=%b err=%b want 0", bus3.out, bus3.ready, bus3.error);
        end
`ifdef MEM_RESPONDER_FAULT_CAPTURE_EN
        checks++;
        if ({fv0, fa0, fv3, fa3} !== 66'h0) begin
            errors++; $display("FAIL reset_capture got %b %h %b %h want 0", fv0, fa0, fv3, fa3);
        end
`endif
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_word_rw();
        logic [31:0] o; logic e; int lat;
        txn(0, 0, 1, 32'h10, 32'hDEADBEEF, 2'b10, o, e, lat);
        m_write(0, 32'h10, 32'hDEADBEEF, 2'b10);
        checks++;
        if (lat !== 1 || e !== 1'b0) begin
            errors++; $display("FAIL word_write got lat=%0d err=%b want lat=1 err=0", lat, e);
        end
        txn(0, 1, 0, 32'h10, 32'h0, 2'b10, o, e, lat);
        checks++;
        if (lat !== 1 || e !== 1'b0 || o !== 32'hDEADBEEF) begin
            errors++; $display("FAIL word_read got lat=%0d err=%b out=%h want 1 0 deadbeef", lat, e, o);
        end
    endtask

    task automatic test_byte_half();
        logic [31:0] o; logic e; int lat;
        txn(0, 0, 1, 32'h13, 32'h0000_00A5, 2'b00, o, e, lat);
        m_write(0, 32'h13, 32'hA5, 2'b00);
        txn(0, 1, 0, 32'h10, 32'h0, 2'b10, o, e, lat);
        checks++;
        if (e !== 1'b0 || o !== 32'hA5ADBEEF) begin
            errors++; $display("FAIL byte_merge got err=%b out=%h want 0 a5adbeef", e, o);
        end
        txn(0, 1, 0, 32'h12, 32'h0, 2'b01, o, e, lat);
        checks++;
        if (e !== 1'b0 || o !== 32'h0000A5AD) begin
            errors++; $display("FAIL half_read got err=%b out=%h want 0 0000a5ad", e, o);
        end
        txn(0, 1, 0, 32'h11, 32'h0, 2'b00, o, e, lat);
        checks++;
        if (e !== 1'b0 || o !== 32'h000000BE) begin
            errors++; $display("FAIL byte_read got err=%b out=%h want 0 000000be", e, o);
        end
    endtask

    task automatic test_faults();
        logic [31:0] o; logic e; int lat;
        logic [31:0] fa [6] = '{32'h11, 32'h12, 32'h10, 32'h12, 32'h10, 32'h13};
        logic [1:0]  fs [6] = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b10, 2'b00};
        logic        fr [6] = '{1, 1, 1, 0, 1, 1};
        logic        fw [6] = '{0, 0, 0, 1, 1, 1};
        txn(0, 1, 0, B0 + S0, 32'h0, 2'b10, o, e, lat);
        checks++;
        if (e !== 1'b1 || o !== 32'h0) begin
            errors++; $display("FAIL out_of_range got err=%b out=%h want 1 0", e, o);
        end
`ifdef MEM_RESPONDER_FAULT_CAPTURE_EN
        checks++;
        if (fv0 !== 1'b1 || fa0 !== B0 + S0) begin
            errors++; $display("FAIL capture_first got v=%b a=%h want 1 %h", fv0, fa0, B0 + S0);
        end
`endif
        for (int i = 0; i < 6; i++) begin
            txn(0, fr[i], fw[i], fa[i], 32'hFFFF_FFFF, fs[i], o, e, lat);
            checks++;
            if (e !== 1'b1 || o !== 32'h0 || lat !== 1) begin
                errors++; $display("FAIL fault_%0d got err=%b out=%h lat=%0d want 1 0 1", i, e, o, lat);
            end
        end
        txn(0, 1, 0, 32'h10, 32'h0, 2'b10, o, e, lat);
        checks++;
        if (e !== 1'b0 || o !== 32'hA5ADBEEF) begin
            errors++; $display("FAIL ram_unchanged got err=%b out=%h want 0 a5adbeef", e, o);
        end
`ifdef MEM_RESPONDER_FAULT_CAPTURE_EN
        checks++;
        if (fv0 !== 1'b1 || fa0 !== B0 + S0) begin
            errors++; $display("FAIL capture_sticky got v=%b a=%h want 1 %h", fv0, fa0, B0 + S0);
        end
`endif
        txn(3, 1, 0, B3 - 32'h4, 32'h0, 2'b10, o, e, lat);
        checks++;
        if (e !== 1'b1 || lat !== 4) begin
            errors++; $display("FAIL below_base got err=%b lat=%0d want 1 4", e, lat);
        end
    endtask

    task automatic test_wait();
        logic [31:0] o; logic e; int lat;
        txn(3, 0, 1, B3 + 32'h20, 32'h1234_5678, 2'b10, o, e, lat);
        m_write(3, B3 + 32'h20, 32'h1234_5678, 2'b10);
        checks++;
        if (lat !== 4 || e !== 1'b0) begin
            errors++; $display("FAIL wait_write got lat=%0d err=%b want 4 0", lat, e);
        end
        txn(3, 0, 1, B3 + 32'h24, 32'hCAFE_F00D, 2'b10, o, e, lat);
        m_write(3, B3 + 32'h24, 32'hCAFE_F00D, 2'b10);
        drive(3, 1, 0, B3 + 32'h20, 32'h0, 2'b10);
        @(posedge clk); #1;
        drive(3, 1, 0, B3 + 32'h25, 32'h0, 2'b00);
        lat = 1;
        while (!bus3.ready && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 4 || bus3.error !== 1'b0 || bus3.out !== 32'h1234_5678) begin
            errors++; $display("FAIL wait_latched got lat=%0d err=%b out=%h want 4 0 12345678", lat, bus3.error, bus3.out);
        end
        drive(3, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] o; logic e; int lat;
        drive(3, 0, 1, B3 + 32'h20, 32'hBAD0_BAD0, 2'b10);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        checks++;
        if ({bus3.out, bus3.ready, bus3.error} !== 34'h0) begin
            errors++; $display("FAIL reset_mid got out=%h rdy=%b err=%b want 0", bus3.out, bus3.ready, bus3.error);
        end
        drive(3, 0, 0, 0, 0, 0);
        lat = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus3.ready) lat++;
        end
        checks++;
        if (lat !== 0) begin
            errors++; $display("FAIL reset_no_ready got %0d ready cycles want 0", lat);
        end
        rst = 1'b1;
        @(posedge clk); #1;
`ifdef MEM_RESPONDER_FAULT_CAPTURE_EN
        checks++;
        if (fv0 !== 1'b0 || fa0 !== 32'h0) begin
            errors++; $display("FAIL capture_cleared got v=%b a=%h want 0 0", fv0, fa0);
        end
`endif
        txn(3, 1, 0, B3 + 32'h20, 32'h0, 2'b10, o, e, lat);
        checks++;
        if (lat !== 4 || e !== 1'b0 || o !== 32'h1234_5678) begin
            errors++; $display("FAIL reset_old_data got lat=%0d err=%b out=%h want 4 0 12345678", lat, e, o);
        end
    endtask

    task automatic test_back_to_back();
        drive(0, 0, 1, 32'h20, 32'h0BAD_CAFE, 2'b10);
        m_write(0, 32'h20, 32'h0BAD_CAFE, 2'b10);
        @(posedge clk); #1;
        checks++;
        if (bus0.ready !== 1'b1) begin
            errors++; $display("FAIL b2b_write_ready got %b want 1", bus0.ready);
        end
        drive(0, 1, 0, 32'h20, 32'h0, 2'b10);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            checks++;
            if (bus0.ready !== 1'b0) begin
                errors++; $display("FAIL b2b_idle_%0d got ready=%b want 0", k, bus0.ready);
            end
            @(posedge clk); #1;
            checks++;
            if (bus0.ready !== 1'b1 || bus0.out !== 32'h0BAD_CAFE) begin
                errors++; $display("FAIL b2b_read_%0d got ready=%b out=%h want 1 0badcafe", k, bus0.ready, bus0.out);
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [31:0] o, a, dt, base, span, eo; logic e, r, w, ef; logic [1:0] s; int lat, d, k;
        for (int dd = 0; dd < 2; dd++) begin
            d = dd * 3;
            base = (d == 0) ? B0 : B3;
            for (int i = 0; i < 16; i++) begin
                dt = $urandom;
                txn(d, 0, 1, base + 32'h100 + 32'(4 * i), dt, 2'b10, o, e, lat);
                m_write(d, base + 32'h100 + 32'(4 * i), dt, 2'b10);
            end
        end
        for (int n = 0; n < 250; n++) begin
            d    = ($urandom_range(0, 1) == 0) ? 0 : 3;
            base = (d == 0) ? B0 : B3;
            span = (d == 0) ? S0 : S3;
            k = $urandom_range(0, 9);
            if (k == 0)      a = base + span + 32'($urandom_range(0, 7));
            else if (k == 1) a = base - 32'($urandom_range(1, 8));
            else             a = base + 32'h100 + 32'($urandom_range(0, 63));
            s  = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            k  = $urandom_range(0, 19);
            r  = (k < 10);
            w  = (k == 0) || (k >= 10);
            dt = $urandom;
            ef = m_fault(r, w, a, base, span, s);
            eo = (r && !w && !ef) ? m_read(d, a, s) : 32'h0;
            txn(d, r, w, a, dt, s, o, e, lat);
            if (w && !r && !ef) m_write(d, a, dt, s);
            checks++;
            if (lat !== ((d == 0) ? 1 : 4) || e !== ef || (r && o !== eo)) begin
                errors++;
                $display("FAIL rand_%0d u%0d r=%b w=%b a=%h s=%b got lat=%0d err=%b out=%h want err=%b out=%h",
                         n, d, r, w, a, s, lat, e, o, ef, eo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_half();
        test_faults();
        test_wait();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the CPU's load/store/fetch port (`rd`, `we`, `addr`, `data`, `size` → `out`, `error`). It owns a word-organised RAM behind a parameterised base address, applies a configurable number of wait states, steers bytes and halfwords into and out of the correct lanes, and flags misaligned, out-of-range and illegal-size accesses. It adds a `ready` strobe so a multicycle control unit can stall on slow memory.

## Interface
- `BASE`, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.
- `DEPTH`, 4096: number of 32-bit words; must be a power of two.
- `WAIT_CYCLES`, 0: extra cycles between acceptance and response (0–15).

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `rd`  in  1  read request
- `we`  in  1  write request
- `addr`  in  32  byte address
- `data`  in  32  write data, right-justified
- `size`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `out`  out  32  read data, right-justified, zero-extended
- `ready`  out  1  one-cycle response strobe
- `error`  out  1  access fault, valid only while `ready`=1

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: when `rd|we`=1, latch `addr`, `data`, `size` and op, then go to WAIT if `WAIT_CYCLES`>0, else RESP. The counter loads `WAIT_CYCLES-1`.
- WAIT: decrement the counter. Go to RESP when it is 0.
- RESP: `ready`=1 for exactly one cycle, then return to IDLE.
- Fault is computed from the latched request:
  - `size`=11.
  - Half with `addr[0]`=1.
  - Word with `addr[1:0]`≠0.
  - `addr-BASE` ≥ `DEPTH*4` (unsigned, 32-bit wrap).
  - `rd` and `we` both high.
- Write: commits in the RESP cycle only when there is no fault.
  - Byte: `data[7:0]` goes to lane `addr[1:0]`.
  - Half: `data[15:0]` goes to lanes selected by `addr[1]`.
  - Word: all four lanes are written.
- Read: RAM word read during acceptance/WAIT. The selected lane is shifted to bit 0 and zero-extended. On a fault `out`=0.
- Sign extension is not performed here; it belongs to the datapath.

## Timing
- Reset values: `out`=0, `ready`=0, `error`=0, state IDLE, counter 0. RAM contents are not reset.
- Latency: request seen in IDLE at cycle 0 → `ready` at cycle `WAIT_CYCLES`+1.
- `out`/`error` are registered and held until the next RESP cycle.
- Initiator holds the request stable until `ready`. Inputs changing in WAIT are ignored because they were latched.
- Back-to-back requests: a request still asserted in the IDLE cycle after RESP is accepted as a new transaction. The initiator must drop `rd`/`we` in that cycle if it has no new access.
- Reset mid-transaction aborts immediately; no write commits and no `ready` is produced.
- Read-after-write to the same address: the write commits in its RESP edge, so the next read returns the new data.

## Configuration
- `MEM_RESPONDER_FAULT_CAPTURE_EN` defined:
  - Adds outputs `fault_addr` (32) and `fault_valid` (1).
  - On the first faulting RESP, latch `addr` and set `fault_valid`. These are sticky until reset; later faults do not overwrite them.
  - Both reset to 0.
- Undefined: the ports are absent and there is no capture logic.

## Structure
- `mem_responder_pkg`:
  - State enum (IDLE, WAIT, RESP).
  - Size constants SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - Fault-check function.
- Sub-module `mem_lane_align`: combinational write-enable mask/data replication and read lane extraction, shared for both directions.

## Test plan
- `WAIT_CYCLES`=0, word write 32'hDEADBEEF @0x10, then word read @0x10 → `ready` at cycle 1 each; `out`=32'hDEADBEEF, `error`=0.
- Byte write 8'hA5 @0x13 over that word, then word read → 32'hA5ADBEEF. Half read @0x12 → 32'h0000A5AD.
- Half read @0x11 and word read @0x12 → `error`=1, `out`=0, RAM unchanged. `size`=11 → `error`=1.
- `WAIT_CYCLES`=3, read → `ready` exactly at cycle 4. `addr` changed during WAIT → response reflects the original address.
- Address `BASE+DEPTH*4` → `error`=1. With the macro: `fault_addr`=that address and `fault_valid`=1; a later fault @0x11 leaves `fault_addr` unchanged.
- `rst` asserted low in WAIT of a write → outputs 0 immediately, no `ready`; a subsequent read returns the old data.
